sensor_sweep_sched: RTL and testbench

Measurement scheduler between the host command/result FIFOs (32-bit, 512-deep, synchronous reset) and a bank of `sonic_sensor` instances. It pops 32-bit commands from the input FIFO. It then sequences each enabled sensor's req/busy handshake one sensor at a time, in round-robin order. Each result is captured, tagged with sensor index and timeout status, and pushed to the output FIFO. It replaces the free-running req/busy wiring in the single-sensor wrapper, and it lets one FIFO pair serve up to eight sensors.

---
 rtl/sensor_sweep_sched.sv | 210 +++++++++++++++++++++
 tb/tb_sensor_sweep_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module   : sensor_sweep_sched
// Purpose  : Measurement scheduler between the host command/result FIFOs and
//            a bank of sonic_sensor instances. It pops one command, then runs
//            the req/busy handshake of each enabled sensor in turn, in index
//            order. Each result is tagged with the sensor index and a timeout
//            flag, then pushed to the result FIFO. Continuous commands repeat
//            the sweep after a programmable gap.
// Ports    : clk, rst (async, active-high)
//            i_cmd_data/i_cmd_empty/o_cmd_rd_en : command FIFO read side
//            o_res_data/i_res_full/o_res_wr_en  : result FIFO write side
//            o_sns_req/i_sns_busy/i_sns_data    : per-sensor handshake
//            o_active    : sweep or gap in progress
//            o_err_count : saturating timeout count
// Revision : 1.0 - initial release
// ============================================================================
module sensor_sweep_sched #(
    parameter int NUM_SENSORS    = 4,
    parameter int TIMEOUT_CYCLES = 6000000,
    parameter int BUSY_RISE_MAX  = 16,
    parameter int GAP_SHIFT      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               i_cmd_data,
    input  logic                      i_cmd_empty,
    output logic                      o_cmd_rd_en,
    output logic [31:0]               o_res_data,
    input  logic                      i_res_full,
    output logic                      o_res_wr_en,
    output logic [NUM_SENSORS-1:0]    o_sns_req,
    input  logic [NUM_SENSORS-1:0]    i_sns_busy,
    input  logic [32*NUM_SENSORS-1:0] i_sns_data,
    output logic                      o_active,
    output logic [7:0]                o_err_count
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = 14 + GAP_SHIFT;

    localparam logic [TO_W-1:0] c_RISE_LAST = TO_W'(BUSY_RISE_MAX - 1);
    localparam logic [TO_W-1:0] c_TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_SELECT    = 4'd3,
        S_REQ       = 4'd4,
        S_WAIT_RISE = 4'd5,
        S_WAIT_FALL = 4'd6,
        S_WRITE     = 4'd7,
        S_GAP       = 4'd8
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [TO_W-1:0]         r_to_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [13:0]             r_gap;
    logic                    r_cont;
    logic [NUM_SENSORS-1:0]  r_mask;
    logic [3:0]              r_ptr;      // one wider than the index so idx+1 never wraps
    logic [2:0]              r_idx;
    logic [NUM_SENSORS-1:0]  r_sns_req;
    logic [31:0]             r_res_data;
    logic                    r_active;
    logic [7:0]              r_err_count;

    logic                    w_op_run;
    logic                    w_found;
    logic [2:0]              w_found_idx;
    logic                    w_busy_sel;
    logic [31:0]             w_data_sel;
    logic [27:0]             w_dist;
    logic                    w_timeout;
    logic                    w_capture;
    logic                    w_unused_cmd;

    assign w_op_run     = (i_cmd_data[31:30] == 2'b01) || (i_cmd_data[31:30] == 2'b10);
    assign w_unused_cmd = ^i_cmd_data;

    // Lowest enabled sensor at or above the pointer; descending scan so the
    // lowest match is the one left standing.
    always_comb begin
        w_found     = 1'b0;
        w_found_idx = 3'd0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (r_mask[i] && (4'(i) >= r_ptr)) begin
                w_found     = 1'b1;
                w_found_idx = 3'(i);
            end
        end
    end

    // Only the selected sensor's busy and data are observed.
    always_comb begin
        w_busy_sel = 1'b0;
        w_data_sel = 32'd0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (r_idx == 3'(i)) begin
                w_busy_sel = i_sns_busy[i];
                w_data_sel = i_sns_data[32*i +: 32];
            end
        end
    end

    assign w_dist    = (w_data_sel[31:28] != 4'd0) ? 28'hFFF_FFFF : w_data_sel[27:0];
    assign w_timeout = ((r_state == S_WAIT_RISE) && !w_busy_sel && (r_to_cnt == c_RISE_LAST)) ||
                       ((r_state == S_WAIT_FALL) &&  w_busy_sel && (r_to_cnt == c_TO_LAST));
    assign w_capture = (r_state == S_WAIT_FALL) && !w_busy_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!i_cmd_empty) w_next = S_FETCH;
            S_FETCH:     w_next = S_DECODE;
            S_DECODE:    w_next = (w_op_run && (i_cmd_data[NUM_SENSORS-1:0] != '0)) ? S_SELECT : S_IDLE;
            S_SELECT: begin
                if (w_found)     w_next = S_REQ;
                else if (r_cont) w_next = S_GAP;
                else             w_next = S_IDLE;
            end
            S_REQ:       w_next = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (w_busy_sel)     w_next = S_WAIT_FALL;
                else if (w_timeout) w_next = S_WRITE;
            end
            S_WAIT_FALL: if (w_capture || w_timeout) w_next = S_WRITE;
            S_WRITE:     if (!i_res_full) w_next = S_SELECT;
            S_GAP: begin
                // A pending command preempts the next sweep only here.
                if (r_gap_cnt == '0) w_next = i_cmd_empty ? S_SELECT : S_FETCH;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_gap       <= '0;
            r_cont      <= 1'b0;
            r_mask      <= '0;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_sns_req   <= '0;
            r_res_data  <= '0;
            r_active    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_sns_req <= '0;
            r_active  <= (w_next != S_IDLE) && (w_next != S_FETCH) && (w_next != S_DECODE);

            case (r_state)
                S_DECODE: begin
                    r_cont <= (i_cmd_data[31:30] == 2'b10);
                    r_gap  <= i_cmd_data[29:16];
                    r_mask <= i_cmd_data[NUM_SENSORS-1:0];
                    r_ptr  <= '0;
                end
                S_SELECT: begin
                    if (w_found) begin
                        r_idx <= w_found_idx;
                        for (int i = 0; i < NUM_SENSORS; i++) begin
                            r_sns_req[i] <= (w_found_idx == 3'(i));
                        end
                    end else begin
                        r_gap_cnt <= GAP_W'(r_gap) << GAP_SHIFT;
                    end
                end
                S_REQ: r_to_cnt <= '0;
                S_WAIT_RISE, S_WAIT_FALL: r_to_cnt <= r_to_cnt + 1'b1;
                S_WRITE: if (!i_res_full) r_ptr <= {1'b0, r_idx} + 4'd1;
                S_GAP: begin
                    if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
                    else                 r_ptr     <= '0;
                end
                default: ;
            endcase

            if (w_timeout) begin
                r_res_data <= {1'b1, r_idx, 28'd0};
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else if (w_capture) begin
                r_res_data <= {1'b0, r_idx, w_dist};
            end
        end
    end

    assign o_cmd_rd_en = (r_state == S_FETCH);
    assign o_res_wr_en = (r_state == S_WRITE) && !i_res_full;
    assign o_res_data  = r_res_data;
    assign o_sns_req   = r_sns_req;
    assign o_active    = r_active;
    assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_sensor_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_sweep_sched
// Purpose  : Bench for sensor_sweep_sched with behavioural sensor and FIFO
//            models. Expected results come from a per-sensor outcome model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_sweep_sched;

    localparam int NS  = 4;
    localparam int TO  = 200;
    localparam int BRM = 16;
    localparam int GS  = 10;

    localparam int M_NORMAL = 0;
    localparam int M_NORISE = 1;
    localparam int M_NOFALL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       cmd_data = 32'd0;
    logic              cmd_empty;
    logic              cmd_rd_en;
    logic [31:0]       res_data;
    logic              res_full;
    logic              res_wr_en;
    logic [NS-1:0]     sns_req;
    logic [NS-1:0]     sns_busy;
    logic [32*NS-1:0]  sns_data;
    logic              active;
    logic [7:0]        err_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int viol   = 0;
    int exp_err = 0;
    int t_push = 0;
    int k, base, base2, rc, rc2, d;
    logic [31:0] rcmd;
    logic [7:0]  rmask;
    logic [31:0] odd_cmds [4];

    logic [31:0] cmd_mem [64];
    int          cmd_wp = 0;
    int          cmd_rp = 0;

    int          mode [NS];
    int          rise [NS];
    int          blen [NS];
    int          scnt [NS];
    logic [31:0] sdata [NS];
    int          req_count [NS];
    int          last_req_cyc [NS];
    logic [NS-1:0] prev_req = '0;

    logic [31:0] got_q [$];
    int          got_cyc [$];

    sensor_sweep_sched #(
        .NUM_SENSORS   (NS),
        .TIMEOUT_CYCLES(TO),
        .BUSY_RISE_MAX (BRM),
        .GAP_SHIFT     (GS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_cmd_data (cmd_data),
        .i_cmd_empty(cmd_empty),
        .o_cmd_rd_en(cmd_rd_en),
        .o_res_data (res_data),
        .i_res_full (res_full),
        .o_res_wr_en(res_wr_en),
        .o_sns_req  (sns_req),
        .i_sns_busy (sns_busy),
        .i_sns_data (sns_data),
        .o_active   (active),
        .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Command FIFO: data appears the cycle after rd_en.
    assign cmd_empty = (cmd_wp == cmd_rp);
    always @(posedge clk) begin
        if (cmd_rd_en && (cmd_rp != cmd_wp)) begin
            cmd_data <= cmd_mem[cmd_rp % 64];
            cmd_rp   <= cmd_rp + 1;
        end
    end

    // Sensor model: cycles since the last req decide busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) scnt[i] <= 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (sns_req[i])                          scnt[i] <= 1;
                else if (scnt[i] != 0 && scnt[i] < 100000) scnt[i] <= scnt[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            sns_busy[i] = 1'b0;
            if (scnt[i] != 0 && mode[i] != M_NORISE && scnt[i] > rise[i])
                sns_busy[i] = (mode[i] == M_NOFALL) || (scnt[i] <= rise[i] + blen[i]);
            sns_data[32*i +: 32] = sdata[i];
        end
    end

    // Monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_wr_en) begin
                got_q.push_back(res_data);
                got_cyc.push_back(cyc);
                if (res_full) viol++;
            end
            if (!$onehot0(sns_req)) viol++;
            if ((sns_req & prev_req) != '0) viol++;
            for (int i = 0; i < NS; i++) begin
                if (sns_req[i]) begin
                    req_count[i]++;
                    last_req_cyc[i] = cyc;
                end
            end
        end
        prev_req = sns_req;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push_cmd(input logic [31:0] w);
        cmd_mem[cmd_wp % 64] = w;
        cmd_wp = cmd_wp + 1;
        t_push = cyc;
    endtask

    // Expected outcome of one sensor's measurement from its configured behaviour.
    function automatic logic [31:0] exp_word(input int i);
        logic [2:0] ix;
        ix = 3'(i);
        if (mode[i] != M_NORMAL)         return {1'b1, ix, 28'd0};
        if (sdata[i][31:28] != 4'd0)     return {1'b0, ix, 28'hFFF_FFFF};
        return {1'b0, ix, sdata[i][27:0]};
    endfunction

    task automatic run_single(input string tag, input logic [31:0] cmd);
        logic [31:0] exp_q [$];
        int b;
        int n;
        b = got_q.size();
        n = 0;
        for (int i = 0; i < NS; i++) begin
            if (cmd[i]) begin
                exp_q.push_back(exp_word(i));
                if (mode[i] != M_NORMAL && exp_err < 255) exp_err++;
            end
        end
        push_cmd(cmd);
        while ((got_q.size() < b + exp_q.size() || active !== 1'b0) && n < 3000) begin
            step(1);
            n++;
        end
        chk_rng({tag, " finish"}, n, 0, 2999);
        step(5);
        chk({tag, " write count"}, 32'(got_q.size() - b), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && (b + j) < got_q.size(); j++)
            chk($sformatf("%s word%0d", tag, j), got_q[b + j], exp_q[j]);
        chk({tag, " err_count"}, 32'(err_count), 32'(exp_err));
        chk({tag, " active low"}, 32'(active), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        res_full = 1'b0;
        for (int i = 0; i < NS; i++) begin
            mode[i] = M_NORMAL; rise[i] = 0; blen[i] = 100; sdata[i] = 32'd0;
        end
        step(3);
        chk("reset sns_req",   32'(sns_req),   32'd0);
        chk("reset active",    32'(active),    32'd0);
        chk("reset err_count", 32'(err_count), 32'd0);
        chk("reset res_data",  res_data,       32'd0);
        chk("reset cmd_rd_en", 32'(cmd_rd_en), 32'd0);
        chk("reset res_wr_en", 32'(res_wr_en), 32'd0);
        rst = 1'b0;
        step(2);

        // Single sweep over sensors 0 and 2.
        sdata[0] = 32'h0000_0123; sdata[2] = 32'h0000_0456;
        rc = req_count[1];
        base = got_q.size();
        run_single("sweep05", 32'h4000_0005);
        if (got_q.size() >= base + 2) begin
            chk("sweep05 first",  got_q[base],     32'h0000_0123);
            chk("sweep05 second", got_q[base + 1], 32'h2000_0456);
        end
        chk_rng("start latency", last_req_cyc[0] - t_push, 4, 4);
        chk("no req sensor1", 32'(req_count[1] - rc), 32'd0);
        chk("cmd consumed", 32'(cmd_empty), 32'd1);

        // Busy never rises.
        mode[1] = M_NORISE;
        base = got_q.size();
        run_single("norise", 32'h4000_0002);
        if (got_q.size() > base) begin
            chk("norise word", got_q[base], 32'h9000_0000);
            chk_rng("norise latency", got_cyc[base] - last_req_cyc[1], BRM, BRM + 2);
        end
        chk("norise err", 32'(err_count), 32'd1);
        mode[1] = M_NORMAL;

        // Busy never falls.
        mode[3] = M_NOFALL;
        base = got_q.size();
        run_single("nofall", 32'h4000_0008);
        if (got_q.size() > base) begin
            chk("nofall word", got_q[base], 32'hB000_0000);
            chk_rng("nofall latency", got_cyc[base] - last_req_cyc[3], TO, TO + 2);
        end
        mode[3] = M_NORMAL;

        // Distance saturation.
        sdata[0] = 32'h3000_0010;
        base = got_q.size();
        run_single("saturate", 32'h4000_0001);
        if (got_q.size() > base) chk("saturate word", got_q[base], 32'h0FFF_FFFF);

        // Commands that must not start a sweep.
        odd_cmds[0] = 32'h4000_0000;
        odd_cmds[1] = 32'h4000_00F0;
        odd_cmds[2] = 32'h0000_000F;
        odd_cmds[3] = 32'hC000_000F;
        for (int c = 0; c < 4; c++) begin
            rc = req_count[0] + req_count[1] + req_count[2] + req_count[3];
            base = got_q.size();
            push_cmd(odd_cmds[c]);
            step(30);
            chk($sformatf("noop%0d req", c),
                32'(req_count[0] + req_count[1] + req_count[2] + req_count[3] - rc), 32'd0);
            chk($sformatf("noop%0d writes", c), 32'(got_q.size() - base), 32'd0);
            chk($sformatf("noop%0d consumed", c), 32'(cmd_empty), 32'd1);
            chk($sformatf("noop%0d active", c), 32'(active), 32'd0);
        end

        // Result FIFO full stalls WRITE.
        sdata[0] = 32'h0000_0ABC; sdata[1] = 32'h0000_0DEF;
        blen[0] = 30; blen[1] = 30;
        res_full = 1'b1;
        base = got_q.size();
        rc = req_count[1];
        push_cmd(32'h4000_0003);
        step(500);
        chk("full no write", 32'(got_q.size() - base), 32'd0);
        chk("full no req1", 32'(req_count[1] - rc), 32'd0);
        chk("full active", 32'(active), 32'd1);
        res_full = 1'b0;
        d = cyc;
        k = 0;
        while (got_q.size() == base && k < 10) begin step(1); k++; end
        if (got_q.size() > base) begin
            chk_rng("full release latency", got_cyc[base] - d, 0, 1);
            chk("full held word", got_q[base], 32'h0000_0ABC);
        end else begin
            chk_rng("full release write", k, 0, 9);
        end
        k = 0;
        while ((got_q.size() < base + 2 || active !== 1'b0) && k < 500) begin step(1); k++; end
        step(5);
        chk("full total writes", 32'(got_q.size() - base), 32'd2);
        if (got_q.size() >= base + 2) chk("full second word", got_q[base + 1], 32'h1000_0DEF);

        // Continuous mode with a 1024-cycle gap, then a stop command.
        sdata[0] = 32'h0000_0777; blen[0] = 50; rise[0] = 0;
        base = got_q.size();
        push_cmd(32'h8001_0001);
        k = 0;
        while (got_q.size() < base + 2 && k < 5000) begin step(1); k++; end
        chk_rng("cont two writes", k, 0, 4999);
        if (got_q.size() >= base + 2) begin
            chk("cont word0", got_q[base],     32'h0000_0777);
            chk("cont word1", got_q[base + 1], 32'h0000_0777);
            chk_rng("cont period", got_cyc[base + 1] - got_cyc[base], 50 + 1024, 50 + 1024 + 16);
        end
        rc = req_count[0];
        k = 0;
        while (req_count[0] == rc && k < 3000) begin step(1); k++; end
        chk_rng("cont third req", k, 0, 2999);
        base2 = got_q.size();
        push_cmd(32'h0000_0000);
        k = 0;
        while (got_q.size() == base2 && k < 500) begin step(1); k++; end
        chk_rng("cont sweep finishes", k, 0, 499);
        if (got_q.size() > base2) chk("cont last word", got_q[base2], 32'h0000_0777);
        step(100);
        chk("stop waits for gap", 32'(cmd_empty), 32'd0);
        chk("gap active", 32'(active), 32'd1);
        k = 0;
        while ((cmd_empty !== 1'b1 || active !== 1'b0) && k < 2000) begin step(1); k++; end
        chk_rng("stop fetched", k, 0, 1999);
        rc2 = req_count[0];
        step(1500);
        chk("stopped no req", 32'(req_count[0] - rc2), 32'd0);
        chk("stopped no write", 32'(got_q.size() - base2), 32'd1);

        // Asynchronous reset in the middle of WAIT_FALL.
        sdata[0] = 32'h0000_0055; blen[0] = 100;
        base = got_q.size();
        rc = req_count[0];
        push_cmd(32'h4000_0001);
        k = 0;
        while (req_count[0] == rc && k < 100) begin step(1); k++; end
        chk_rng("arst req seen", k, 0, 99);
        step(20);
        #2 rst = 1'b1;
        #1;
        chk("arst sns_req",   32'(sns_req),   32'd0);
        chk("arst active",    32'(active),    32'd0);
        chk("arst err_count", 32'(err_count), 32'd0);
        chk("arst res_wr_en", 32'(res_wr_en), 32'd0);
        exp_err = 0;
        step(3);
        rst = 1'b0;
        step(150);
        chk("arst no write", 32'(got_q.size() - base), 32'd0);

        // Randomized sweeps against the outcome model.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NS; i++) begin
                k = int'($urandom_range(0, 9));
                mode[i] = (k == 0) ? M_NORISE : ((k == 1) ? M_NOFALL : M_NORMAL);
                rise[i] = int'($urandom_range(0, 12));
                blen[i] = int'($urandom_range(1, 60));
                sdata[i] = $urandom();
                if ($urandom_range(0, 1) == 1) sdata[i][31:28] = 4'd0;
            end
            rmask = 8'($urandom());
            if (rmask[3:0] == 4'd0) rmask[0] = 1'b1;
            rcmd = {2'b01, 14'($urandom()), 8'h00, rmask};
            run_single($sformatf("rand%0d", it), rcmd);
        end

        chk("protocol violations", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
